// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative 32-bit multiply/divide unit with architectural HI/LO
//            registers. MULT/MULTU run a 32-cycle shift-add, DIV/DIVU run a
//            32-cycle restoring division on operand magnitudes, followed by
//            one sign-fix cycle. MTHI/MTLO write HI/LO in a single cycle.
// Ports    : clk      - clock, all state changes on rising edge
//            resetn   - asynchronous active-low reset
//            start_i  - request strobe (ignored while busy)
//            op_i     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO, others no-op
//            a_i,b_i  - rs / rt operands
//            flush_i  - abort in-flight operation / drop request
//            busy_o   - MULT/DIV in flight
//            done_o   - one-cycle pulse when HI/LO receive a new result
//            hi_o,lo_o- HI / LO registers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      state_q,   state_d;
   logic [5:0]  cnt_q,     cnt_d;
   // acc[64:32] = partial product / partial remainder,
   // acc[31:0]  = multiplier bits / dividend bits shifting into quotient
   logic [64:0] acc_q,     acc_d;
   logic [31:0] opb_q,     opb_d;     // multiplicand or divisor magnitude
   logic        is_div_q,  is_div_d;
   logic        neg_res_q, neg_res_d; // negate product / quotient
   logic        neg_rem_q, neg_rem_d; // negate remainder (dividend sign)
   logic        div0_q,    div0_d;
   logic [31:0] hi_q,      hi_d;
   logic [31:0] lo_q,      lo_d;
   logic        busy_q,    busy_d;
   logic        done_q,    done_d;

   // Operand preparation: ops 000/010 are the signed flavours
   logic        w_signed, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   assign w_signed = ~op_i[0];
   assign w_a_neg  = w_signed & a_i[31];
   assign w_b_neg  = w_signed & b_i[31];
   assign w_a_mag  = w_a_neg ? -a_i : a_i;
   assign w_b_mag  = w_b_neg ? -b_i : b_i;

   // One shift-add multiply step
   logic [32:0] w_mul_sum;
   assign w_mul_sum = acc_q[64:32] + (acc_q[0] ? {1'b0, opb_q} : 33'd0);

   // One restoring-division step; bit 33 of the trial is the borrow
   logic [32:0] w_div_shift;
   logic [33:0] w_div_trial;
   assign w_div_shift = {acc_q[63:32], acc_q[31]};
   assign w_div_trial = {1'b0, w_div_shift} - {2'b00, opb_q};

   // Sign correction of the finished magnitudes
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix, w_rem_fix;
   assign w_prod_fix = neg_res_q ? -acc_q[63:0] : acc_q[63:0];
   // With a zero divisor the restoring loop leaves quotient = all ones and
   // remainder = |a|; skipping quotient negation and restoring the dividend
   // sign on the remainder gives lo = 0xFFFFFFFF, hi = a directly.
   assign w_quo_fix  = (neg_res_q && !div0_q) ? -acc_q[31:0] : acc_q[31:0];
   assign w_rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               case (op_i)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     acc_d     = {33'd0, w_a_mag};
                     opb_d     = w_b_mag;
                     is_div_d  = op_i[1];
                     neg_res_d = w_a_neg ^ w_b_neg;
                     neg_rem_d = w_a_neg;
                     div0_d    = (b_i == 32'd0);
                     cnt_d     = 6'd0;
                     busy_d    = 1'b1;
                     state_d   = S_CALC;
                  end
                  3'b100:  hi_d = a_i;
                  3'b101:  lo_d = a_i;
                  default: ;
               endcase
            end
         end

         S_CALC: begin
            if (flush_i) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               if (is_div_q) begin
                  if (!w_div_trial[33]) begin
                     acc_d = {w_div_trial[32:0], acc_q[30:0], 1'b1};
                  end else begin
                     acc_d = {w_div_shift, acc_q[30:0], 1'b0};
                  end
               end else begin
                  acc_d = {1'b0, w_mul_sum, acc_q[31:1]};
               end
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (!flush_i) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = w_rem_fix;
                  lo_d = w_quo_fix;
               end else begin
                  hi_d = w_prod_fix[63:32];
                  lo_d = w_prod_fix[31:0];
               end
            end
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         acc_q     <= 65'd0;
         opb_q     <= 32'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit. Directed and random
//            MULT/MULTU/DIV/DIVU requests are compared against a plain
//            64-bit arithmetic model; MTHI/MTLO, flush, ignored start and
//            asynchronous reset behaviour are checked as directed steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        flush;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mul_div_unit dut (
      .clk     (clk),
      .resetn  (resetn),
      .start_i (start),
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .flush_i (flush),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   always #5 clk = ~clk;

   // Reference model: {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint sx, sy, ux, uy, q, m, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      r  = 0;
      case (o)
         3'b000: r = sx * sy;
         3'b001: r = ux * uy;
         default: begin
            if (y == 32'd0) begin
               r = longint'({x, 32'hFFFF_FFFF});
            end else begin
               q = (o == 3'b010) ? sx / sy : ux / uy;
               m = (o == 3'b010) ? sx % sy : ux % uy;
               r = longint'({m[31:0], q[31:0]});
            end
         end
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Issue a MULT/DIV and watch 36 cycles after the accepting edge.
   // If inject is set, a different request is strobed during busy.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit inject,
                         input string tag);
      int busy_cnt, done_cnt, done_at;
      logic [63:0] e;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin done_cnt++; done_at = k; end
         if (inject && k == 5) begin
            start = 1'b1; op = ~o & 3'b011; a = ~x; b = y ^ 32'h5A5A_0F0F;
         end
         if (inject && k == 6) start = 1'b0;
      end
      e = model(o, x, y);
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      check({tag, ".busy_cycles"}, busy_cnt, 33);
      check({tag, ".done_count"},  done_cnt, 1);
      check({tag, ".done_cycle"},  done_at,  34);
      check({tag, ".hi"}, hi, exp_hi);
      check({tag, ".lo"}, lo, exp_lo);
   endtask

   task automatic run_mt(input logic [2:0] o, input logic [31:0] x,
                         input bit do_flush, input string tag);
      @(negedge clk);
      start = 1'b1; op = o; a = x; flush = do_flush;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      if (!do_flush) begin
         if (o == 3'b100) exp_hi = x;
         if (o == 3'b101) exp_lo = x;
      end
      @(negedge clk);
      check({tag, ".hi"},   hi,   exp_hi);
      check({tag, ".lo"},   lo,   exp_lo);
      check({tag, ".busy"}, busy, 32'd0);
   endtask

   initial begin
      int busy_seen, done_seen;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      resetn = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.hi",   hi,   32'd0);
      check("reset.lo",   lo,   32'd0);
      check("reset.busy", busy, 32'd0);
      check("reset.done", done, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Directed arithmetic cases
      run_op(3'b000, 32'hFFFF_FFFD, 32'd7,        1'b0, "mult_neg3x7");
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
      run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
      run_op(3'b010, 32'hFFFF_FFF9, 32'd2,        1'b0, "div_neg7by2");
      run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
      run_op(3'b011, 32'd100,       32'd0,        1'b0, "divu_by0");
      run_mt(3'b101, 32'h0000_1234, 1'b0, "mtlo");
      run_op(3'b010, 32'hFFFF_FF9C, 32'd0,        1'b0, "div_neg_by0");
      run_mt(3'b100, 32'hCAFE_F00D, 1'b0, "mthi");
      run_mt(3'b100, 32'h1111_2222, 1'b1, "mthi_flushed");
      run_mt(3'b110, 32'h3333_4444, 1'b0, "reserved_op");

      // Start during busy must not disturb the running operation
      run_op(3'b000, 32'h0001_2345, 32'hFFFE_DCBA, 1'b1, "mult_ignore_start");

      // Flush mid-multiply: flush held during cycle E0+10
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'h7654_3210; b = 32'h0000_0BAD;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush.busy_after", busy, 32'd0);
      busy_seen = 0; done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (done) done_seen++;
      end
      check("flush.busy_seen", busy_seen, 0);
      check("flush.done_seen", done_seen, 0);
      check("flush.hi", hi, exp_hi);
      check("flush.lo", lo, exp_lo);

      // Asynchronous reset in the middle of a DIVU
      @(negedge clk);
      start = 1'b1; op = 3'b011; a = 32'hDEAD_BEEF; b = 32'd13;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      check("areset.hi",   hi,   exp_hi);
      check("areset.lo",   lo,   exp_lo);
      check("areset.busy", busy, 32'd0);
      check("areset.done", done, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      run_op(3'b011, 32'hDEAD_BEEF, 32'd13, 1'b0, "divu_after_reset");

      // Random MULT/MULTU/DIV/DIVU against the model
      for (int n = 0; n < 20; n++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = 32'($urandom_range(1, 50));
            3:       rb = -32'($urandom_range(1, 50));
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", n, ro));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
